// File: rtl/factorial_ctrl.sv
// Sequencer for the factorial datapath: accepts n on go, range-checks it and
// steps a shared multi-cycle multiplier through the products n*(n-1)*...*2.
module factorial_ctrl #(
  parameter int DATA_W = 32,
  parameter int N_W    = 4,
  parameter int N_MAX  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [N_W-1:0]    n,
  output logic              mul_start,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  input  logic [DATA_W-1:0] mul_p,
  input  logic              mul_done,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] result
);

  // Handshakes: go is a level sampled only in IDLE; mul_start is a one-cycle
  // request and mul_a/mul_b stay stable until the one-cycle mul_done (with
  // mul_p valid) is sampled in MUL_WAIT; done is a one-cycle completion pulse.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_MUL_REQ  = 3'd2,
    S_MUL_WAIT = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t              state;
  logic [N_W-1:0]      n_q;
  logic [N_W-1:0]      cnt;
  logic [DATA_W-1:0]   prod;

  // Operands come straight from the running registers, so they hold still
  // for the whole request/wait window.
  assign mul_a = prod;
  assign mul_b = {{(DATA_W-N_W){1'b0}}, cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      n_q       <= '0;
      cnt       <= '0;
      prod      <= '0;
      mul_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      result    <= '0;
    end else begin
      mul_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            n_q    <= n;
            error  <= 1'b0;
            result <= '0;
            busy   <= 1'b1;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (32'(n_q) > N_MAX) begin
            error  <= 1'b1;
            result <= '0;
            done   <= 1'b1;
            state  <= S_DONE;
          end else if (n_q <= N_W'(1)) begin
            result <= DATA_W'(1);
            done   <= 1'b1;
            state  <= S_DONE;
          end else if (n_q == N_W'(2)) begin
            result <= DATA_W'(2);
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            prod      <= {{(DATA_W-N_W){1'b0}}, n_q};
            cnt       <= n_q - N_W'(1);
            mul_start <= 1'b1;
            state     <= S_MUL_REQ;
          end
        end
        S_MUL_REQ: begin
          state <= S_MUL_WAIT;
        end
        S_MUL_WAIT: begin
          if (mul_done) begin
            prod <= mul_p;
            cnt  <= cnt - N_W'(1);
            // Multiplying by 2 is the last step of the chain.
            if (cnt == N_W'(2)) begin
              result <= mul_p;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              mul_start <= 1'b1;
              state     <= S_MUL_REQ;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
